fifo_param: RTL and testbench

// - Next-generation synchronous FIFO, parametrised in data width and depth (power of two).
// - Adds occupancy count, programmable almost-full/almost-empty, overflow/underflow pulses,

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_if.sv | 35 +++
 rtl/fifo_mem.sv | 28 ++
 rtl/fifo_param.sv | 113 +++++++++++
 tb/tb_fifo_param.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_param slice.
// - DEF_DATA_WIDTH / DEF_DEPTH : default geometry used by fifo_param and fifo_if
// - clog2()                    : ceiling log2, used to size pointer/index fields
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_if.sv
// Producer/consumer bundle for fifo_param.
// - master : drives clear, write_enb, read_enb, data_in; observes data and status
// - slave  : the FIFO side; drives data_out, full/empty/almost flags, count,
//            overflow/underflow pulses
interface fifo_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = clog2(DEF_DEPTH)
) ();

  logic                  clear;
  logic                  write_enb;
  logic                  read_enb;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear, write_enb, read_enb, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clear, write_enb, read_enb, data_in,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// Storage array for fifo_param: DEPTH x DATA_WIDTH registers, no reset.
// - clock : write clock
// - we    : write strobe, waddr/wdata : write port (synchronous)
// - raddr : read address, rdata : read data (asynchronous)
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// Synchronous FIFO with occupancy count, programmable almost-full/almost-empty,
// overflow/underflow pulses, synchronous flush and optional FWFT read mode.
// - clock  : single clock, rising edge
// - resetn : asynchronous reset, active low
// - bus    : fifo_if slave (clear, write_enb, read_enb, data_in in;
//            data_out, full, empty, almost_full, almost_empty, count,
//            overflow, underflow out)
module fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_WIDTH = clog2(DEPTH),
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2,
  parameter bit          FWFT       = 1'b0
) (
  input  logic  clock,
  input  logic  resetn,
  fifo_if.slave bus
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  logic [CW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_next;
  logic                  full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wr_acc, rd_acc;

  // Accept decisions use the registered flags, so no input reaches a flag
  // without passing through a register.
  assign wr_acc = bus.write_enb & ~full_q  & ~bus.clear;
  assign rd_acc = bus.read_enb  & ~empty_q & ~bus.clear;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clock (clock),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (bus.data_in),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (rdata)
  );

  always_comb begin
    count_next = count_q;
    if (wr_acc && !rd_acc) begin
      count_next = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_next = count_q - CW'(1);
    end
  end

  // Flags are registered from count_next so they are exact the cycle after
  // the push/pop that changed the occupancy.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else if (bus.clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + CW'(1);
      end
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + CW'(1);
        dout_q   <= rdata;
      end
      count_q <= count_next;
      full_q  <= (count_next == CW'(DEPTH));
      empty_q <= (count_next == '0);
      af_q    <= (count_next >= CW'(AF_THRESH));
      ae_q    <= (count_next <= CW'(AE_THRESH));
      ovf_q   <= bus.write_enb & full_q;
      unf_q   <= bus.read_enb & empty_q;
    end
  end

  // FWFT presents the head word directly; it is forced to zero while empty so
  // the output matches the registered mode's reset/flush value.
  assign bus.data_out     = FWFT ? (empty_q ? '0 : rdata) : dout_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned AF    = DEPTH - 2;
  localparam int unsigned AE    = 2;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  int total = 0;
  int bad   = 0;

  int          model_count = 0;
  logic [7:0]  sb[$];
  logic [7:0]  model_dout  = '0;
  logic        exp_ovf     = 1'b0;
  logic        exp_unf     = 1'b0;

  fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus   ();
  fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_f ();

  assign bus_f.clear     = bus.clear;
  assign bus_f.write_enb = bus.write_enb;
  assign bus_f.read_enb  = bus.read_enb;
  assign bus_f.data_in   = bus.data_in;

  fifo_param #(
    .DATA_WIDTH (DW), .DEPTH (DEPTH), .ADDR_WIDTH (AW),
    .AF_THRESH (AF), .AE_THRESH (AE), .FWFT (1'b0)
  ) dut (
    .clock (clock), .resetn (resetn), .bus (bus)
  );

  fifo_param #(
    .DATA_WIDTH (DW), .DEPTH (DEPTH), .ADDR_WIDTH (AW),
    .AF_THRESH (AF), .AE_THRESH (AE), .FWFT (1'b1)
  ) dut_f (
    .clock (clock), .resetn (resetn), .bus (bus_f)
  );

  always #5 clock = ~clock;

  // Drives one cycle of stimulus, updates the reference model/scoreboard,
  // and returns 1 ns after the active edge with inputs idle again.
  task automatic step(input logic we, input logic re, input logic [7:0] din, input logic clr);
    bit wa, ra;
    wa      = we && !clr && (model_count < int'(DEPTH));
    ra      = re && !clr && (model_count > 0);
    exp_ovf = we && !clr && (model_count == int'(DEPTH));
    exp_unf = re && !clr && (model_count == 0);
    bus.write_enb = we;
    bus.read_enb  = re;
    bus.data_in   = din;
    bus.clear     = clr;
    if (clr) begin
      sb.delete();
      model_count = 0;
      model_dout  = '0;
    end else begin
      if (ra) model_dout = sb.pop_front();
      if (wa) sb.push_back(din);
      model_count = model_count + int'(wa) - int'(ra);
    end
    @(posedge clock);
    #1;
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    bus.clear     = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
    total++; if (bus.almost_full !== 1'b0) begin bad++; $display("FAIL reset_af: got %b want 0", bus.almost_full); end
    total++; if (bus.almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae: got %b want 1", bus.almost_empty); end
    total++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin bad++; $display("FAIL reset_pulses: got ovf=%b unf=%b want 0 0", bus.overflow, bus.underflow); end
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", bus.data_out); end
    total++; if (bus_f.data_out !== 8'h00) begin bad++; $display("FAIL reset_fwft_dout: got %h want 00", bus_f.data_out); end
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < int'(DEPTH); i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0);
      total++; if (bus.count !== 5'(model_count)) begin bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count, model_count); end
      total++; if (bus.almost_full !== (model_count >= int'(AF))) begin bad++; $display("FAIL fill_af[%0d]: got %b at count %0d", i, bus.almost_full, model_count); end
      total++; if (bus.almost_empty !== (model_count <= int'(AE))) begin bad++; $display("FAIL fill_ae[%0d]: got %b at count %0d", i, bus.almost_empty, model_count); end
      total++; if (bus.full !== (model_count == int'(DEPTH))) begin bad++; $display("FAIL fill_full[%0d]: got %b at count %0d", i, bus.full, model_count); end
      total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL fill_empty[%0d]: got %b want 0", i, bus.empty); end
    end
    total++; if (bus.full !== 1'b1 || bus.count !== 5'd16) begin bad++; $display("FAIL fill_final: got full=%b count=%0d want 1 16", bus.full, bus.count); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < int'(DEPTH); i++) begin
      total++; if (bus_f.data_out !== sb[0]) begin bad++; $display("FAIL drain_fwft[%0d]: got %h want %h", i, bus_f.data_out, sb[0]); end
      step(1'b0, 1'b1, 8'h00, 1'b0);
      total++; if (bus.data_out !== model_dout || bus.data_out !== 8'(i)) begin bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, bus.data_out, model_dout); end
      total++; if (bus.count !== 5'(model_count)) begin bad++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, bus.count, model_count); end
    end
    total++; if (bus.empty !== 1'b1 || bus.almost_empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got empty=%b ae=%b want 1 1", bus.empty, bus.almost_empty); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    step(1'b1, 1'b1, 8'hAA, 1'b0);
    total++; if (bus.overflow !== 1'b1 || exp_ovf !== 1'b1) begin bad++; $display("FAIL ovf_pulse: got %b want 1", bus.overflow); end
    total++; if (bus.count !== 5'd15) begin bad++; $display("FAIL ovf_count: got %0d want 15", bus.count); end
    total++; if (bus.data_out !== 8'h20) begin bad++; $display("FAIL ovf_pop: got %h want 20", bus.data_out); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL ovf_full: got %b want 0", bus.full); end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_release: got %b want 0", bus.overflow); end
    while (model_count > 0) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      total++; if (bus.data_out !== model_dout) begin bad++; $display("FAIL ovf_drain: got %h want %h", bus.data_out, model_dout); end
    end
    total++; if (bus.data_out !== 8'h2F || bus.empty !== 1'b1) begin bad++; $display("FAIL ovf_last: got %h empty=%b want 2f 1", bus.data_out, bus.empty); end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b1, 8'h00, 1'b0);
    total++; if (bus.underflow !== exp_unf || exp_unf !== 1'b1) begin bad++; $display("FAIL unf_pulse: got %b want 1", bus.underflow); end
    total++; if (bus.data_out !== 8'h2F) begin bad++; $display("FAIL unf_hold: got %h want 2f", bus.data_out); end
    total++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin bad++; $display("FAIL unf_state: got count=%0d empty=%b want 0 1", bus.count, bus.empty); end
    total++; if (bus_f.data_out !== 8'h00) begin bad++; $display("FAIL unf_fwft_empty: got %h want 00", bus_f.data_out); end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL unf_release: got %b want 0", bus.underflow); end
    step(1'b1, 1'b1, 8'h77, 1'b0);
    total++; if (bus.count !== 5'd1 || bus.underflow !== 1'b1) begin bad++; $display("FAIL unf_pushpop: got count=%0d unf=%b want 1 1", bus.count, bus.underflow); end
    total++; if (bus_f.data_out !== 8'h77) begin bad++; $display("FAIL unf_fwft_head: got %h want 77", bus_f.data_out); end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    total++; if (bus.data_out !== 8'h77 || bus.empty !== 1'b1) begin bad++; $display("FAIL unf_pop: got %h empty=%b want 77 1", bus.data_out, bus.empty); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      total++; if (bus_f.data_out !== sb[0]) begin bad++; $display("FAIL wrap_fwft[%0d]: got %h want %h", i, bus_f.data_out, sb[0]); end
      step(1'b1, 1'b1, 8'(8'h90 + i), 1'b0);
      total++; if (bus.data_out !== model_dout) begin bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, bus.data_out, model_dout); end
      total++; if (bus.count !== 5'd3 || bus.empty !== 1'b0 || bus.full !== 1'b0 || bus.almost_empty !== 1'b0 || bus.almost_full !== 1'b0) begin
        bad++; $display("FAIL wrap_flags[%0d]: got count=%0d e=%b f=%b ae=%b af=%b want 3 0 0 0 0", i, bus.count, bus.empty, bus.full, bus.almost_empty, bus.almost_full);
      end
    end
    while (model_count > 0) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      total++; if (bus.data_out !== model_dout) begin bad++; $display("FAIL wrap_drain: got %h want %h", bus.data_out, model_dout); end
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'hC7, 1'b0);
    total++; if (bus.count !== 5'd7) begin bad++; $display("FAIL clr_pre: got %0d want 7", bus.count); end
    step(1'b1, 1'b0, 8'hEE, 1'b1);
    total++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.almost_empty !== 1'b1) begin bad++; $display("FAIL clr_state: got count=%0d e=%b ae=%b want 0 1 1", bus.count, bus.empty, bus.almost_empty); end
    total++; if (bus.overflow !== 1'b0 || bus.data_out !== 8'h00) begin bad++; $display("FAIL clr_out: got ovf=%b dout=%h want 0 00", bus.overflow, bus.data_out); end
    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 1'b0, 8'(8'hD0 + i), 1'b0);
    step(1'b1, 1'b1, 8'hEF, 1'b1);
    total++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.full !== 1'b0 || bus.count !== 5'd0) begin
      bad++; $display("FAIL clr_full: got ovf=%b unf=%b full=%b count=%0d want 0 0 0 0", bus.overflow, bus.underflow, bus.full, bus.count);
    end
    total++; if (bus_f.data_out !== 8'h00) begin bad++; $display("FAIL clr_fwft: got %h want 00", bus_f.data_out); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    total++; if (bus.data_out !== 8'h50) begin bad++; $display("FAIL rst_pre: got %h want 50", bus.data_out); end
    bus.write_enb = 1'b1;
    bus.data_in   = 8'h99;
    @(negedge clock);
    resetn = 1'b0;
    #1;
    sb.delete();
    model_count = 0;
    model_dout  = '0;
    total++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin bad++; $display("FAIL rst_mid_state: got count=%0d e=%b f=%b want 0 1 0", bus.count, bus.empty, bus.full); end
    total++; if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin bad++; $display("FAIL rst_mid_af_ae: got ae=%b af=%b want 1 0", bus.almost_empty, bus.almost_full); end
    total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL rst_mid_dout: got %h want 00", bus.data_out); end
    bus.write_enb = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    total++; if (bus.count !== 5'd1 || bus_f.data_out !== 8'h3C) begin bad++; $display("FAIL rst_mid_after: got count=%0d head=%h want 1 3c", bus.count, bus_f.data_out); end
  endtask

  initial begin
    bus.clear     = 1'b0;
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    bus.data_in   = '0;
    test_reset();
    test_fill();
    test_drain();
    test_overflow();
    test_underflow();
    test_wrap();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
